alu_mul_seq: RTL and testbench

Multi-cycle radix-4 Booth multiplier, the parametrised sequential successor to the combinational datapath multiplier. It retires one recoded bit pair per clock, so the array is replaced by a single adder and shifter. Supports signed and unsigned operands, selected per operation. It sits in the ALU beside the divider, and the control unit drives it with a start/busy/done handshake.

---
 rtl/alu_mul_seq.sv | 137 +++++++++++++
 tb/tb_alu_mul_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Sequential radix-4 Booth multiplier. Retires one recoded bit pair of the
// multiplier per clock. It uses a single accumulator adder and a digit shifter.
// Handshake: start is taken only in IDLE or DONE. busy is high for every cycle
// in which an iteration is pending. done pulses for one cycle, and P is valid
// from that cycle until the next accepted start.
module alu_mul_seq #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   P
);

   // Operands carry two extra bits. Unsigned values therefore stay positive
   // when the Booth recoder treats them as two's complement.
   localparam int W2 = WIDTH + 2;
   localparam int N  = W2 / 2;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam int AW = 2 * W2;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [W2-1:0]       a_q, a_d;      // extended multiplicand
   logic [W2-1:0]       na_q, na_d;    // its negation, precomputed at load
   logic [W2-1:0]       b_q, b_d;      // multiplier, shifted right 2 per step
   logic                bm1_q, bm1_d;  // bit below the current pair
   logic [KW-1:0]       k_q, k_d;      // pair counter
   logic [AW-1:0]       acc_q, acc_d;
   logic [2*WIDTH-1:0]  p_q, p_d;

   logic [W2-1:0]       a_ext, b_ext;
   logic [AW-1:0]       a_sx, na_sx, digit, addend, sum;
   logic [2:0]          triple;

   // Extend incoming operands by sign or zero depending on mode.
   always_comb begin
      a_ext = signed_mode ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
      b_ext = signed_mode ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};
   end

   // Booth digit selection and accumulation for the current pair.
   always_comb begin
      triple = {b_q[1], b_q[0], bm1_q};
      a_sx   = {{W2{a_q[W2-1]}}, a_q};
      na_sx  = {{W2{na_q[W2-1]}}, na_q};
      digit  = '0;
      case (triple)
         3'b001, 3'b010: digit = a_sx;
         3'b011:         digit = a_sx << 1;
         3'b100:         digit = na_sx << 1;
         3'b101, 3'b110: digit = na_sx;
         default:        digit = '0;
      endcase
      addend = digit << {k_q, 1'b0};
      sum    = acc_q + addend;
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      na_d    = na_q;
      b_d     = b_q;
      bm1_d   = bm1_q;
      k_d     = k_q;
      acc_d   = acc_q;
      p_d     = p_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            done = (state_q == S_DONE);
            if (start) begin
               a_d     = a_ext;
               na_d    = -a_ext;
               b_d     = b_ext;
               bm1_d   = 1'b0;
               k_d     = '0;
               acc_d   = '0;
               state_d = S_CALC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            busy  = 1'b1;
            acc_d = sum;
            b_d   = b_q >> 2;
            bm1_d = b_q[1];
            k_d   = k_q + KW'(1);
            if (k_q == K_LAST) begin
               p_d     = sum[2*WIDTH-1:0];
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers. Reset aborts any operation in flight.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         na_q    <= '0;
         b_q     <= '0;
         bm1_q   <= 1'b0;
         k_q     <= '0;
         acc_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         na_q    <= na_d;
         b_q     <= b_d;
         bm1_q   <= bm1_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         p_q     <= p_d;
      end
   end

   assign P = p_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq at WIDTH=32 and WIDTH=8, sharing clock, reset and
// operand buses. Each instance has its own start.
module tb_alu_mul_seq;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        start32 = 1'b0;
   logic        start8 = 1'b0;
   logic        sm = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        busy32, done32, busy8, done8;
   logic [63:0] P32;
   logic [15:0] P8;

   int errors = 0;
   int checks = 0;
   logic [63:0] exp_q[$];
   logic [63:0] last_p32 = '0;
   logic [63:0] last_p8 = '0;

   alu_mul_seq #(.WIDTH(32)) dut32 (
      .clk(clk), .clr(clr), .start(start32), .signed_mode(sm),
      .A(A), .B(B), .busy(busy32), .done(done32), .P(P32)
   );

   alu_mul_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .clr(clr), .start(start8), .signed_mode(sm),
      .A(A[7:0]), .B(B[7:0]), .busy(busy8), .done(done8), .P(P8)
   );

   // clock
   always #5 clk = ~clk;

   // Runaway guard.
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Reference product: plain wide multiply of the extended operands.
   function automatic logic [63:0] model(input bit s8, input bit smode,
                                         input logic [31:0] a, input logic [31:0] b);
      logic [63:0] xa, xb, r;
      if (s8) begin
         xa = smode ? {{56{a[7]}}, a[7:0]} : {56'b0, a[7:0]};
         xb = smode ? {{56{b[7]}}, b[7:0]} : {56'b0, b[7:0]};
      end else begin
         xa = smode ? {{32{a[31]}}, a} : {32'b0, a};
         xb = smode ? {{32{b[31]}}, b} : {32'b0, b};
      end
      r = xa * xb;
      if (s8) r = {48'b0, r[15:0]};
      return r;
   endfunction

   function automatic logic [63:0] p_of(input bit s8);
      return s8 ? {48'b0, P8} : P32;
   endfunction

   function automatic logic busy_of(input bit s8);
      return s8 ? busy8 : busy32;
   endfunction

   function automatic logic done_of(input bit s8);
      return s8 ? done8 : done32;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Drive one request. The start edge is the next posedge. hold keeps start high.
   task automatic launch(input bit s8, input bit smode, input logic [31:0] a,
                         input logic [31:0] b, input bit hold);
      sm = smode;
      A  = a;
      B  = b;
      if (s8) start8 = 1'b1; else start32 = 1'b1;
      exp_q.push_back(model(s8, smode, a, b));
      @(posedge clk);
      #1;
      if (!hold) begin
         start8  = 1'b0;
         start32 = 1'b0;
      end
   endtask

   // Wait (bounded) for done. Check latency, busy span, P hold and product.
   task automatic wait_done(input bit s8, input bit disturb, input string tag);
      int n = s8 ? 5 : 17;
      int idx = 0;
      int busy_cnt = 0;
      bit seen = 1'b0;
      bit hold_ok = 1'b1;
      logic [63:0] prev = s8 ? last_p8 : last_p32;
      logic [63:0] e;
      while (idx < n + 8) begin
         @(negedge clk);
         if (done_of(s8)) begin
            seen = 1'b1;
            break;
         end
         if (busy_of(s8)) busy_cnt++;
         if (p_of(s8) !== prev) hold_ok = 1'b0;
         if (disturb && idx == 4) begin
            A  = $urandom;
            B  = $urandom;
            sm = ~sm;
            if (s8) start8 = 1'b1; else start32 = 1'b1;
         end
         if (disturb && idx == 5) begin
            start8  = 1'b0;
            start32 = 1'b0;
         end
         idx++;
      end
      check({tag, " done_seen"}, 64'(seen), 64'd1);
      check({tag, " latency"}, 64'(idx), 64'(n));
      check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(n));
      check({tag, " p_held"}, 64'(hold_ok), 64'd1);
      check({tag, " busy_at_done"}, 64'(busy_of(s8)), 64'd0);
      e = exp_q.pop_front();
      check({tag, " product"}, p_of(s8), e);
      if (s8) last_p8 = e; else last_p32 = e;
   endtask

   initial begin
      bit quiet;
      logic [31:0] ra, rb;

      // reset state
      #12;
      check("rst busy32", 64'(busy32), 64'd0);
      check("rst done32", 64'(done32), 64'd0);
      check("rst p32", P32, 64'd0);
      check("rst busy8", 64'(busy8), 64'd0);
      check("rst p8", 64'(P8), 64'd0);
      @(negedge clk);
      clr = 1'b1;

      // basic signed product and single-cycle done pulse
      launch(0, 1, -32'sd7, 32'd3, 0);
      wait_done(0, 0, "neg7x3");
      check("neg7x3 const", P32, 64'hFFFF_FFFF_FFFF_FFEB);
      @(negedge clk);
      check("done_one_cycle", 64'(done32), 64'd0);
      check("idle_after_done", 64'(busy32), 64'd0);

      // all-ones and most-negative corners
      launch(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      wait_done(0, 0, "u_ones");
      check("u_ones const", P32, 64'hFFFF_FFFE_0000_0001);
      launch(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      wait_done(0, 0, "s_ones");
      check("s_ones const", P32, 64'h1);
      launch(0, 1, 32'h8000_0000, 32'h8000_0000, 0);
      wait_done(0, 0, "s_minmin");
      check("s_minmin const", P32, 64'h4000_0000_0000_0000);

      // back-to-back: start held high through CALC and into DONE
      launch(0, 1, 32'd100, 32'd7, 1);
      wait_done(0, 0, "b2b_first");
      A  = 32'd5;
      B  = 32'd6;
      sm = 1'b1;
      exp_q.push_back(model(0, 1, 32'd5, 32'd6));
      @(posedge clk);
      #1;
      start32 = 1'b0;
      wait_done(0, 0, "b2b_second");
      check("b2b const", P32, 64'd30);

      // start pulse and operand changes mid-CALC are ignored
      launch(0, 1, 32'd1234, -32'sd77, 0);
      wait_done(0, 1, "disturb");

      // asynchronous reset at k=8 aborts the operation
      launch(0, 1, 32'h1357, 32'h2468, 0);
      repeat (9) @(negedge clk);
      #2;
      clr = 1'b0;
      #1;
      check("abort busy", 64'(busy32), 64'd0);
      check("abort done", 64'(done32), 64'd0);
      check("abort p", P32, 64'd0);
      void'(exp_q.pop_back());
      last_p32 = '0;
      @(negedge clk);
      clr = 1'b1;
      quiet = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (done32 || busy32) quiet = 1'b0;
      end
      check("abort no_done", 64'(quiet), 64'd1);
      launch(0, 1, 32'd12, -32'sd12, 0);
      wait_done(0, 0, "after_abort");
      check("after_abort const", P32, -64'sd144);

      // WIDTH=8 corners
      launch(1, 0, 32'hFF, 32'hFF, 0);
      wait_done(1, 0, "w8_u255");
      check("w8_u255 const", 64'(P8), 64'hFE01);
      launch(1, 1, 32'h80, 32'hFF, 0);
      wait_done(1, 0, "w8_m128xm1");
      check("w8_m128xm1 const", 64'(P8), 64'h0080);
      launch(1, 1, 32'h80, 32'h7F, 0);
      wait_done(1, 0, "w8_m128x127");
      check("w8_m128x127 const", 64'(P8), 64'hC080);

      // random regression, both widths and both modes
      for (int w = 0; w < 2; w++) begin
         for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 100; i++) begin
               ra = $urandom;
               rb = $urandom;
               if ($urandom_range(0, 9) == 0) ra = (w == 1) ? 32'h80 : 32'h8000_0000;
               if ($urandom_range(0, 9) == 0) rb = 32'hFFFF_FFFF;
               launch(w[0], m[0], ra, rb, 0);
               wait_done(w[0], 0, "random");
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
